radix2_divider: RTL and testbench



---
 rtl/radix2_divider.sv | 106 ++++++++++
 tb/tb_radix2_divider.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/radix2_divider.sv
// Unsigned 32-bit restoring radix-2 divider, one quotient bit per clock.
// Optional DIVIDER_ZERO_BYPASS_EN finishes divide-by-zero in one cycle.
module radix2_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_q;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic [31:0] r_quo;
  logic [31:0] r_remo;
  logic [4:0]  r_cnt;
  logic        r_done;

  logic [32:0] w_trial;
  logic        w_bit;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_q_nxt;
  logic        w_zero;

  // Borrow out of the 33-bit trial marks a negative result.
  assign w_trial   = {r_rem, r_q[31]} - {1'b0, r_div};
  assign w_bit     = ~w_trial[32];
  assign w_rem_nxt = w_bit ? w_trial[31:0]
                           : {r_rem[30:0], r_q[31]};
  assign w_q_nxt   = {r_q[30:0], w_bit};

`ifdef DIVIDER_ZERO_BYPASS_EN
  logic r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_zero <= 1'b0;
    else if (r_state == S_IDLE && start)
      r_zero <= (divisor == 32'd0);
  end

  assign w_zero = r_zero;
`else
  assign w_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_quo   <= '0;
      r_remo  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_q     <= dividend;
            r_div   <= divisor;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_zero) begin
            // r_q still holds the untouched dividend here
            r_quo   <= '1;
            r_remo  <= r_q;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_q   <= w_q_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_quo   <= w_q_nxt;
              r_remo  <= w_rem_nxt;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_remo;

endmodule

// File: tb/tb_radix2_divider.sv
// Directed bench for radix2_divider with a scoreboard of
// expected quotient/remainder/latency per launched operation.
module tb_radix2_divider;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] lat;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  sb_t sb[$];
  int  n_assert;
  int  n_fail;
  int  cyc_cnt;
  int  t_acc;

  radix2_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a,
                        input logic [31:0] b);
    sb_t e;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
`ifdef DIVIDER_ZERO_BYPASS_EN
      e.lat = 32'd1;
`else
      e.lat = 32'd32;
`endif
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.lat = 32'd32;
    end
    sb.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    t_acc    = cyc_cnt;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0005;
  endtask

  task automatic wait_done(input string tag);
    sb_t e;
    int  n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_lat"}, cyc_cnt - t_acc, e.lat);
    chk({tag, "_quo"}, quotient, e.q);
    chk({tag, "_rem"}, remainder, e.r);
    @(posedge clk);
    #1;
    chk({tag, "_fall"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold"}, quotient, e.q);
  endtask

  initial begin
    int seen;
    n_assert = 0;
    n_fail   = 0;
    cyc_cnt  = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quo", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    launch(32'd10, 32'd7);
    wait_done("d10_7");
    launch(32'd100, 32'd100);
    wait_done("d100_100");
    launch(32'd100, 32'd7);
    wait_done("d100_7");
    launch(32'd100, 32'd0);
    wait_done("d100_0");
    launch(32'd70, 32'd150);
    wait_done("d70_150");
    launch(32'hFFFF_FFFF, 32'd1);
    wait_done("dmax_1");
    launch(32'hFFFF_FFFF, 32'h0001_0000);
    wait_done("dmax_64k");

    launch(32'd1000, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 32'd12345;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore");

    launch(32'd500, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    chk("busy_hold", quotient, 32'd1000 / 32'd7);
    rst = 1'b1;
    #1;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quo", quotient, 32'd0);
    chk("abort_rem", remainder, 32'd0);
    void'(sb.pop_front());
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 32'd0);

    launch(32'h1234_5678, 32'h0000_1234);
    wait_done("post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
